rtc_lector_rafaga: RTL and testbench

//  Parametrised burst reader for the parallel RTC bus: on request, reads N_REGS RTC

---
 rtl/rtc_lector_rafaga.sv | 182 ++++++++++++++++++
 tb/tb_rtc_lector_rafaga.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_lector_rafaga.sv
// Burst reader for the parallel RTC bus. Walks an address table, one
// address phase + one data phase per register, and returns each byte as
// {reg_idx, data_q} with a one-cycle data_valid strobe.
module rtc_lector_rafaga #(
  parameter int                  N_REGS   = 9,
  parameter int                  IDX_W    = 4,
  parameter int                  T_LOW    = 4,
  parameter int                  T_GAP    = 2,
  parameter logic [8*N_REGS-1:0] ADDR_TAB = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25,
                                             8'h24, 8'h23, 8'h22, 8'h21}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             do_it_leer,
  input  logic             continuo,
  output logic             a_d,
  output logic             cs,
  output logic             rd,
  output logic             wr,
  output logic             reg_to_rtc,
  output logic             rtc_to_reg,
  output logic [7:0]       addr_out,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_q,
  output logic [IDX_W-1:0] reg_idx,
  output logic             data_valid,
  output logic             busy,
  output logic             sweep_done
);

  localparam int TMAX = (T_LOW > T_GAP) ? T_LOW : T_GAP;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int NTAB = 2 ** IDX_W;
  localparam int TW   = 8 * NTAB;

  localparam logic [CW-1:0]    LOW_LAST = CW'(T_LOW - 1);
  localparam logic [CW-1:0]    GAP_LAST = CW'(T_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP_A,
    S_DATA,
    S_GAP_D
  } state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             lvl_q;
  logic             phase_end;
  logic             capture;
  logic             sd_nxt;

  // Table padded to a power of two so an IDX_W-bit index always selects
  // a legal entry; entries beyond N_REGS are never reached.
  logic [NTAB-1:0][7:0] tab;
  assign tab = TW'(ADDR_TAB);

  // Strobe phases last T_LOW cycles, gap phases T_GAP cycles.
  always_comb begin
    phase_end = 1'b0;
    if (state == S_ADDR || state == S_DATA) phase_end = (cnt == LOW_LAST);
    else if (state == S_GAP_A || state == S_GAP_D) phase_end = (cnt == GAP_LAST);
  end

  // Next-state, phase counter and table index.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    capture = 1'b0;
    sd_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        // Single-sweep mode needs a fresh 0->1 edge; holding the level does not repeat.
        if (do_it_leer && (continuo || !lvl_q)) nxt = S_ADDR;
      end
      S_ADDR: begin
        if (phase_end) begin
          nxt     = S_GAP_A;
          cnt_nxt = '0;
        end
      end
      S_GAP_A: begin
        if (phase_end) begin
          nxt     = S_DATA;
          cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (phase_end) begin
          capture = 1'b1;
          nxt     = S_GAP_D;
          cnt_nxt = '0;
        end
      end
      S_GAP_D: begin
        if (phase_end) begin
          cnt_nxt = '0;
          if (idx == LAST_IDX) begin
            sd_nxt  = 1'b1;
            idx_nxt = '0;
            nxt     = (continuo && do_it_leer) ? S_ADDR : S_IDLE;
          end else if (do_it_leer) begin
            idx_nxt = idx + IDX_W'(1);
            nxt     = S_ADDR;
          end else begin
            // Request withdrawn: abandon the sweep, next request restarts at 0.
            idx_nxt = '0;
            nxt     = S_IDLE;
          end
        end
      end
      default: begin
        nxt     = S_IDLE;
        cnt_nxt = '0;
        idx_nxt = '0;
      end
    endcase
  end

  // FSM state, counters and request-level history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      lvl_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      lvl_q <= do_it_leer;
    end
  end

  // Bus outputs registered from the next state so they line up with the
  // state register and never glitch; rd and wr come from disjoint states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_d        <= 1'b1;
      cs         <= 1'b1;
      rd         <= 1'b1;
      wr         <= 1'b1;
      reg_to_rtc <= 1'b0;
      rtc_to_reg <= 1'b0;
      addr_out   <= '0;
      busy       <= 1'b0;
    end else begin
      a_d        <= (nxt != S_ADDR);
      cs         <= !(nxt == S_ADDR || nxt == S_DATA);
      wr         <= (nxt != S_ADDR);
      rd         <= (nxt != S_DATA);
      reg_to_rtc <= (nxt == S_ADDR);
      rtc_to_reg <= (nxt == S_DATA);
      busy       <= (nxt != S_IDLE);
      if (nxt == S_ADDR) addr_out <= tab[idx_nxt];
    end
  end

  // Result capture on the last data-phase cycle, plus completion strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      reg_idx    <= '0;
      data_valid <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      data_valid <= capture;
      sweep_done <= sd_nxt;
      if (capture) begin
        data_q  <= data_in;
        reg_idx <= idx;
      end
    end
  end

endmodule

// File: tb/tb_rtc_lector_rafaga.sv
// Directed bench: default-parameter reader against a small RTC bus model,
// plus a minimal 1-register / 1-cycle-phase instance.
module tb_rtc_lector_rafaga;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, do_it_leer, continuo;
  logic       a_d, cs, rd, wr, reg_to_rtc, rtc_to_reg;
  logic [7:0] addr_out, data_in, data_q;
  logic [3:0] reg_idx;
  logic       data_valid, busy, sweep_done;

  logic       do_it_leer2, continuo2;
  logic       a_d2, cs2, rd2, wr2, reg_to_rtc2, rtc_to_reg2;
  logic [7:0] addr_out2, data_in2, data_q2;
  logic [0:0] reg_idx2;
  logic       data_valid2, busy2, sweep_done2;

  rtc_lector_rafaga dut (
    .clk(clk), .reset(reset), .do_it_leer(do_it_leer), .continuo(continuo),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .reg_to_rtc(reg_to_rtc),
    .rtc_to_reg(rtc_to_reg), .addr_out(addr_out), .data_in(data_in),
    .data_q(data_q), .reg_idx(reg_idx), .data_valid(data_valid),
    .busy(busy), .sweep_done(sweep_done)
  );

  rtc_lector_rafaga #(.N_REGS(1), .IDX_W(1), .T_LOW(1), .T_GAP(1), .ADDR_TAB(8'h30)) dut2 (
    .clk(clk), .reset(reset), .do_it_leer(do_it_leer2), .continuo(continuo2),
    .a_d(a_d2), .cs(cs2), .rd(rd2), .wr(wr2), .reg_to_rtc(reg_to_rtc2),
    .rtc_to_reg(rtc_to_reg2), .addr_out(addr_out2), .data_in(data_in2),
    .data_q(data_q2), .reg_idx(reg_idx2), .data_valid(data_valid2),
    .busy(busy2), .sweep_done(sweep_done2)
  );

  // RTC model: latches the address phase, answers addr^A5 while rd/cs are low.
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk) if (!wr && !a_d) lat_addr <= addr_out;
  assign data_in  = (!rd && !cs) ? (lat_addr ^ 8'hA5) : 8'hFF;
  assign data_in2 = (!rd2 && !cs2) ? 8'h95 : 8'hFF;

  logic [71:0] tab_v = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

  typedef struct {
    logic [3:0] idx;
    logic [7:0] dat;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int dv_cnt = 0, sd_cnt = 0, rd_cnt = 0, addr_cnt = 0, sd2_cnt = 0;
  int first_addr_cyc = 0;
  int sd_cyc[$];
  int sd2_cyc[$];
  logic [7:0] addr_log[$];
  logic prev_wr = 1'b1, prev_rd = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_regs(input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      e.idx = 4'(i);
      e.dat = tab_v[8*i +: 8] ^ 8'hA5;
      q.push_back(e);
    end
  endtask

  // Per-cycle bus rules and the scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rd_wr_overlap", {31'd0, rd | wr}, 32'd1);
      check("reg_to_rtc_rule", {31'd0, !reg_to_rtc || (!a_d && !wr)}, 32'd1);
      check("rd_wr_overlap2", {31'd0, rd2 | wr2}, 32'd1);
      check("reg_to_rtc_rule2", {31'd0, !reg_to_rtc2 || (!a_d2 && !wr2)}, 32'd1);
      check("rtc_to_reg_rule2", {31'd0, rtc_to_reg2}, {31'd0, !rd2});
      check("cs_rule2", {31'd0, cs2}, {31'd0, rd2 & wr2});
      if (!wr2) check("addr_out2", {24'd0, addr_out2}, 32'h30);
      if (data_valid) begin
        dv_cnt++;
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_dv: observed reg_idx=%0d data=%0h expected no data_valid", reg_idx, data_q);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          check("dv_idx", {28'd0, reg_idx}, {28'd0, e.idx});
          check("dv_data", {24'd0, data_q}, {24'd0, e.dat});
        end
      end
      if (data_valid2) check("dv2", {23'd0, reg_idx2, data_q2}, {23'd0, 1'b0, 8'h95});
      if (sweep_done) begin
        sd_cnt++;
        sd_cyc.push_back(cyc);
      end
      if (sweep_done2) begin
        sd2_cnt++;
        sd2_cyc.push_back(cyc);
      end
      if (!wr && prev_wr) begin
        if (addr_cnt == 0) first_addr_cyc = cyc;
        addr_cnt++;
        addr_log.push_back(addr_out);
      end
      if (!rd && prev_rd) rd_cnt++;
      prev_wr = wr;
      prev_rd = rd;
    end else begin
      prev_wr = 1'b1;
      prev_rd = 1'b1;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // which: 0 = sweep_done count, 1 = data-phase count, 2 = dut2 sweep_done count
  task automatic wait_cnt(input int which, input int target, input int budget, input string tag);
    int c;
    for (int i = 0; i < budget; i++) begin
      c = (which == 0) ? sd_cnt : (which == 1) ? rd_cnt : sd2_cnt;
      if (c >= target) break;
      step(1);
    end
    c = (which == 0) ? sd_cnt : (which == 1) ? rd_cnt : sd2_cnt;
    check(tag, {31'd0, c >= target}, 32'd1);
  endtask

  initial begin
    int b_dv, b_sd, b_addr, b_rd, b2;
    reset = 1'b0; do_it_leer = 1'b1; continuo = 1'b1;
    do_it_leer2 = 1'b1; continuo2 = 1'b1;
    step(3);
    // Reset state
    check("rst_strobes", {28'd0, a_d, cs, rd, wr}, 32'hF);
    check("rst_dirs", {30'd0, reg_to_rtc, rtc_to_reg}, 32'd0);
    check("rst_addr_data", {16'd0, addr_out, data_q}, 32'd0);
    check("rst_flags", {25'd0, reg_idx, data_valid, busy, sweep_done}, 32'd0);

    // Continuous sweeps from reset release; second sweep is the last.
    push_regs(0, 8);
    push_regs(0, 8);
    reset = 1'b1;
    wait_cnt(0, 1, 200, "t1_sweep1_timeout");
    check("t1_sweep1_cycle", sd_cyc.size() > 0 ? sd_cyc[0] - first_addr_cyc : -1, 32'd108);
    continuo = 1'b0;
    wait_cnt(0, 2, 200, "t1_sweep2_timeout");
    check("t1_sweep2_cycle", sd_cyc.size() > 1 ? sd_cyc[1] - first_addr_cyc : -1, 32'd216);
    step(20);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_dv_count", dv_cnt, 32'd18);
    check("t1_sd_count", sd_cnt, 32'd2);
    check("t1_q_empty", q.size(), 32'd0);
    for (int i = 0; i < 9; i++)
      check("t1_addr_order", {24'd0, addr_log[i]}, {24'd0, tab_v[8*i +: 8]});
    check("t1_addr_count", addr_cnt, 32'd18);

    // Single sweep per rising edge, level held high does not repeat.
    do_it_leer = 1'b0;
    step(5);
    b_dv = dv_cnt; b_sd = sd_cnt;
    push_regs(0, 8);
    do_it_leer = 1'b1;
    step(150);
    check("t2_dv_count", dv_cnt - b_dv, 32'd9);
    check("t2_sd_count", sd_cnt - b_sd, 32'd1);
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_q_empty", q.size(), 32'd0);
    do_it_leer = 1'b0;
    step(3);

    // Request dropped during the data phase of idx 3.
    b_dv = dv_cnt; b_sd = sd_cnt; b_addr = addr_cnt; b_rd = rd_cnt;
    push_regs(0, 3);
    do_it_leer = 1'b1;
    wait_cnt(1, b_rd + 4, 100, "t3_data3_timeout");
    check("t3_in_data", {31'd0, rd}, 32'd0);
    do_it_leer = 1'b0;
    step(30);
    check("t3_dv_count", dv_cnt - b_dv, 32'd4);
    check("t3_sd_none", sd_cnt - b_sd, 32'd0);
    check("t3_addr_count", addr_cnt - b_addr, 32'd4);
    check("t3_idle", {31'd0, busy}, 32'd0);
    check("t3_q_empty", q.size(), 32'd0);

    // Reset during a data phase.
    b_dv = dv_cnt; b_rd = rd_cnt;
    do_it_leer = 1'b1;
    wait_cnt(1, b_rd + 1, 40, "t4_data_timeout");
    reset = 1'b0;
    #1;
    check("t4_async_strobes", {29'd0, cs, rd, wr}, 32'h7);
    check("t4_async_flags", {30'd0, data_valid, busy}, 32'd0);
    do_it_leer = 1'b0;
    step(3);
    reset = 1'b1;
    step(20);
    check("t4_idle", {30'd0, busy, cs}, 32'd1);
    check("t4_no_dv", dv_cnt - b_dv, 32'd0);

    // Minimal instance: 4-cycle transactions, sweep_done every 4 cycles.
    b2 = sd2_cnt;
    wait_cnt(2, b2 + 4, 60, "t5_timeout");
    check("t5_busy", {31'd0, busy2}, 32'd1);
    for (int i = 1; i < 4; i++)
      check("t5_period", sd2_cyc.size() > b2 + i ? sd2_cyc[b2 + i] - sd2_cyc[b2 + i - 1] : -1, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
